// File: rtl/fib_write_scoreboard.sv
// Bus-snooping scoreboard for the lab CPU Fibonacci program.
// Checks table writes and running-sum writes in order; latches the first error.
module fib_write_scoreboard #(
    parameter int            AW       = 8,
    parameter int            DW       = 8,
    parameter int            N_FIB    = 7,
    parameter logic [AW-1:0] F_BASE   = AW'(8'hF8),
    parameter logic [AW-1:0] SUM_ADDR = AW'(8'hF3),
    parameter logic [DW-1:0] F0       = DW'(1),
    parameter logic [DW-1:0] F1       = DW'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [AW-1:0]    addr,
    input  logic             wr,
    input  logic [DW-1:0]    data,
    output logic [N_FIB-1:0] f_ok,
    output logic [N_FIB-2:0] sum_ok,
    output logic [1:0]       state,
    output logic [1:0]       err_code,
    output logic [AW-1:0]    err_addr,
    output logic [DW-1:0]    err_data,
    output logic [DW-1:0]    err_exp
);

    localparam logic [AW-1:0] T_LAST = F_BASE + AW'(N_FIB - 1);
    localparam logic [AW-1:0] SK_MAX = AW'(N_FIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        PASS = 2'b10,
        FAIL = 2'b11
    } state_t;

    state_t          r_state;
    logic [DW-1:0]   r_ta;
    logic [DW-1:0]   r_tb;
    logic [AW-1:0]   r_fi;
    logic [DW-1:0]   r_sexp;
    logic [DW-1:0]   r_sa;
    logic [DW-1:0]   r_sb;
    logic [AW-1:0]   r_sk;

    logic            w_tab;
    logic            w_sum;
    logic            w_done;
    logic            w_live;
    logic [AW-1:0]   w_j;
    logic            w_tok;
    logic            w_sok;
    logic [1:0]      w_code;
    logic [DW-1:0]   w_exp;
    logic [N_FIB-1:0] w_fbit;
    logic [N_FIB-2:0] w_sbit;

    assign w_tab  = wr && (addr >= F_BASE) && (addr <= T_LAST);
    assign w_sum  = wr && (addr == SUM_ADDR);
    assign w_j    = addr - F_BASE;
    assign w_done = (&f_ok) && (&sum_ok);
    assign w_live = (r_state == IDLE) || ((r_state == RUN) && !w_done);
    assign w_fbit = {{(N_FIB-1){1'b0}}, 1'b1} << r_fi;
    assign w_sbit = {{(N_FIB-2){1'b0}}, 1'b1} << r_sk;
    assign state  = r_state;

    always_comb begin
        w_tok  = 1'b0;
        w_sok  = 1'b0;
        w_code = 2'b00;
        w_exp  = '0;
        if (w_tab) begin
            if (w_j != r_fi) begin
                w_code = 2'b10;
            end else if (data == r_ta) begin
                w_tok = 1'b1;
            end else begin
                w_code = 2'b01;
                w_exp  = r_ta;
            end
        end else if (w_sum) begin
            if (r_sk == SK_MAX) begin
                w_code = 2'b11;
            end else if (data == r_sexp) begin
                w_sok = 1'b1;
            end else begin
                w_code = 2'b01;
                w_exp  = r_sexp;
            end
        end
    end

    // Sum generator: r_sexp = S(sk), r_sa/r_sb = next two Fibonacci addends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ta     <= F0;
            r_tb     <= F1;
            r_fi     <= '0;
            r_sexp   <= F0 + F1;
            r_sa     <= F0 + F1;
            r_sb     <= F0 + F1 + F1;
            r_sk     <= '0;
            f_ok     <= '0;
            sum_ok   <= '0;
            err_code <= '0;
            err_addr <= '0;
            err_data <= '0;
            err_exp  <= '0;
        end else if (clr) begin
            r_state  <= IDLE;
            r_ta     <= F0;
            r_tb     <= F1;
            r_fi     <= '0;
            r_sexp   <= F0 + F1;
            r_sa     <= F0 + F1;
            r_sb     <= F0 + F1 + F1;
            r_sk     <= '0;
            f_ok     <= '0;
            sum_ok   <= '0;
            err_code <= '0;
            err_addr <= '0;
            err_data <= '0;
            err_exp  <= '0;
        end else if (w_live) begin
            if (w_tok) begin
                f_ok    <= f_ok | w_fbit;
                r_ta    <= r_tb;
                r_tb    <= r_ta + r_tb;
                r_fi    <= r_fi + AW'(1);
                r_state <= RUN;
            end
            if (w_sok) begin
                sum_ok  <= sum_ok | w_sbit;
                r_sexp  <= r_sexp + r_sa;
                r_sa    <= r_sb;
                r_sb    <= r_sa + r_sb;
                r_sk    <= r_sk + AW'(1);
                r_state <= RUN;
            end
            if (w_code != 2'b00) begin
                r_state  <= FAIL;
                err_code <= w_code;
                err_addr <= addr;
                err_data <= data;
                err_exp  <= w_exp;
            end
        end else if ((r_state == RUN) && w_done) begin
            r_state <= PASS;
        end
    end

endmodule

// File: tb/tb_fib_write_scoreboard.sv
// Bench for fib_write_scoreboard: vector table, directed corner cases,
// and randomized writes against an array-based reference model.
module tb_fib_write_scoreboard;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;

    logic [6:0]  f0_ok;
    logic [5:0]  s0_ok;
    logic [1:0]  st0, ec0;
    logic [7:0]  ea0, ed0, ex0;
    logic [13:0] f1_ok;
    logic [12:0] s1_ok;
    logic [1:0]  st1, ec1;
    logic [7:0]  ea1, ed1, ex1;

    always #5 clk = ~clk;

    fib_write_scoreboard u0 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .addr(addr), .wr(wr),
        .data(data), .f_ok(f0_ok), .sum_ok(s0_ok), .state(st0),
        .err_code(ec0), .err_addr(ea0), .err_data(ed0), .err_exp(ex0)
    );

    fib_write_scoreboard #(
        .AW(8), .DW(8), .N_FIB(14), .F_BASE(8'hC0), .SUM_ADDR(8'hB0),
        .F0(8'd1), .F1(8'd1)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .addr(addr), .wr(wr),
        .data(data), .f_ok(f1_ok), .sum_ok(s1_ok), .state(st1),
        .err_code(ec1), .err_addr(ea1), .err_data(ed1), .err_exp(ex1)
    );

    int npass = 0;
    int ntot  = 0;

    logic [7:0] fib[7];
    logic [7:0] sums[6];
    logic [7:0] fib1[14];
    logic [7:0] sums1[13];

    int         m_state, m_fi, m_sk;
    logic [6:0] m_fok;
    logic [5:0] m_sok;
    logic [1:0] m_code;
    logic [7:0] m_ea, m_ed, m_ex;

    typedef struct {
        logic [7:0] a;
        logic       w;
        logic [7:0] d;
        logic [6:0] fo;
        logic [5:0] so;
        logic [1:0] st;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    task automatic model_reset();
        m_state = 0; m_fi = 0; m_sk = 0;
        m_fok = '0; m_sok = '0; m_code = '0;
        m_ea = '0; m_ed = '0; m_ex = '0;
    endtask

    task automatic model_fail(input logic [1:0] c, input logic [7:0] e);
        m_state = 3; m_code = c; m_ea = addr; m_ed = data; m_ex = e;
    endtask

    task automatic model_edge();
        int j;
        if (clr) begin
            model_reset();
        end else if (m_state == 1 && m_fok == 7'h7F && m_sok == 6'h3F) begin
            m_state = 2;
        end else if (m_state < 2 && wr) begin
            if (addr >= 8'hF8 && addr <= 8'hFE) begin
                j = int'(addr) - 248;
                if (j != m_fi) model_fail(2'b10, 8'h00);
                else if (data == fib[j]) begin
                    m_fok[j] = 1'b1; m_fi++; m_state = 1;
                end else model_fail(2'b01, fib[j]);
            end else if (addr == 8'hF3) begin
                if (m_sk == 6) model_fail(2'b11, 8'h00);
                else if (data == sums[m_sk]) begin
                    m_sok[m_sk] = 1'b1; m_sk++; m_state = 1;
                end else model_fail(2'b01, sums[m_sk]);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wrt(input logic [7:0] a, input logic [7:0] d);
        addr = a; data = d; wr = 1'b1;
        cyc();
        wr = 1'b0;
    endtask

    task automatic clear();
        clr = 1'b1; wr = 1'b0;
        cyc();
        clr = 1'b0;
    endtask

    task automatic chk_model();
        chk("rnd_state", st0, m_state);
        chk("rnd_f_ok", f0_ok, m_fok);
        chk("rnd_sum_ok", s0_ok, m_sok);
        chk("rnd_code", ec0, m_code);
        chk("rnd_eaddr", ea0, m_ea);
        chk("rnd_edata", ed0, m_ed);
        chk("rnd_eexp", ex0, m_ex);
    endtask

    initial begin
        logic [7:0] acc;
        int r;

        fib[0] = 8'd1; fib[1] = 8'd1;
        for (int i = 2; i < 7; i++) fib[i] = fib[i-1] + fib[i-2];
        for (int k = 0; k < 6; k++) begin
            acc = '0;
            for (int i = 0; i <= k + 1; i++) acc = acc + fib[i];
            sums[k] = acc;
        end
        fib1[0] = 8'd1; fib1[1] = 8'd1;
        for (int i = 2; i < 14; i++) fib1[i] = fib1[i-1] + fib1[i-2];
        for (int k = 0; k < 13; k++) begin
            acc = '0;
            for (int i = 0; i <= k + 1; i++) acc = acc + fib1[i];
            sums1[k] = acc;
        end

        vt[0]  = '{8'hF8, 1'b1, 8'h01, 7'h01, 6'h00, 2'b01};
        vt[1]  = '{8'hF3, 1'b1, 8'h02, 7'h01, 6'h01, 2'b01};
        vt[2]  = '{8'hF9, 1'b1, 8'h01, 7'h03, 6'h01, 2'b01};
        vt[3]  = '{8'hF3, 1'b1, 8'h04, 7'h03, 6'h03, 2'b01};
        vt[4]  = '{8'hFA, 1'b1, 8'h02, 7'h07, 6'h03, 2'b01};
        vt[5]  = '{8'hF3, 1'b1, 8'h07, 7'h07, 6'h07, 2'b01};
        vt[6]  = '{8'hFB, 1'b1, 8'h03, 7'h0F, 6'h07, 2'b01};
        vt[7]  = '{8'hF3, 1'b1, 8'h0C, 7'h0F, 6'h0F, 2'b01};
        vt[8]  = '{8'hFC, 1'b1, 8'h05, 7'h1F, 6'h0F, 2'b01};
        vt[9]  = '{8'hF3, 1'b1, 8'h14, 7'h1F, 6'h1F, 2'b01};
        vt[10] = '{8'hFD, 1'b1, 8'h08, 7'h3F, 6'h1F, 2'b01};
        vt[11] = '{8'hF3, 1'b1, 8'h21, 7'h3F, 6'h3F, 2'b01};
        vt[12] = '{8'hFE, 1'b1, 8'h0D, 7'h7F, 6'h3F, 2'b01};
        vt[13] = '{8'h00, 1'b0, 8'h00, 7'h7F, 6'h3F, 2'b10};
        vt[14] = '{8'hF8, 1'b1, 8'h01, 7'h7F, 6'h3F, 2'b10};

        rst_n = 1'b0; clr = 1'b0; wr = 1'b0; addr = '0; data = '0;
        model_reset();
        #12;
        chk("rst_state", st0, 2'b00);
        chk("rst_f_ok", f0_ok, 7'h00);
        chk("rst_sum_ok", s0_ok, 6'h00);
        chk("rst_code", ec0, 2'b00);
        chk("rst_state1", st1, 2'b00);
        rst_n = 1'b1;
        #1;

        // Interleaved good run
        for (int i = 0; i < 15; i++) begin
            addr = vt[i].a; wr = vt[i].w; data = vt[i].d;
            cyc();
            chk($sformatf("vec%0d_f_ok", i), f0_ok, vt[i].fo);
            chk($sformatf("vec%0d_sum_ok", i), s0_ok, vt[i].so);
            chk($sformatf("vec%0d_state", i), st0, vt[i].st);
        end
        wr = 1'b0;
        chk("vec_code", ec0, 2'b00);

        // Value mismatch, then frozen
        clear();
        chk("clr_state", st0, 2'b00);
        wrt(8'hF8, 8'h01); wrt(8'hF9, 8'h01); wrt(8'hFA, 8'h03);
        chk("mis_state", st0, 2'b11);
        chk("mis_code", ec0, 2'b01);
        chk("mis_addr", ea0, 8'hFA);
        chk("mis_data", ed0, 8'h03);
        chk("mis_exp", ex0, 8'h02);
        chk("mis_f_ok", f0_ok, 7'h03);
        wrt(8'hFA, 8'h02); wrt(8'hFB, 8'h03); wrt(8'hF3, 8'h02);
        chk("frz_state", st0, 2'b11);
        chk("frz_f_ok", f0_ok, 7'h03);
        chk("frz_sum_ok", s0_ok, 6'h00);
        chk("frz_code", ec0, 2'b01);
        chk("frz_addr", ea0, 8'hFA);
        chk("frz_data", ed0, 8'h03);

        // Skip and repeat
        clear();
        wrt(8'hF8, 8'h01); wrt(8'hFA, 8'h02);
        chk("skip_state", st0, 2'b11);
        chk("skip_code", ec0, 2'b10);
        chk("skip_addr", ea0, 8'hFA);
        chk("skip_exp", ex0, 8'h00);
        clear();
        wrt(8'hF8, 8'h01); wrt(8'hF8, 8'h01);
        chk("rep_code", ec0, 2'b10);
        chk("rep_addr", ea0, 8'hF8);

        // clr beats a simultaneous excess sum write
        clear();
        for (int i = 0; i < 7; i++) wrt(8'(248 + i), fib[i]);
        for (int k = 0; k < 6; k++) wrt(8'hF3, sums[k]);
        addr = 8'hF3; data = 8'h99; wr = 1'b1; clr = 1'b1;
        cyc();
        wr = 1'b0; clr = 1'b0;
        chk("clrw_state", st0, 2'b00);
        chk("clrw_f_ok", f0_ok, 7'h00);
        chk("clrw_sum_ok", s0_ok, 6'h00);
        chk("clrw_code", ec0, 2'b00);

        // Excess sum write
        clear();
        wrt(8'hF8, 8'h01);
        for (int k = 0; k < 6; k++) wrt(8'hF3, sums[k]);
        chk("exs_pre", st0, 2'b01);
        wrt(8'hF3, 8'h55);
        chk("exs_state", st0, 2'b11);
        chk("exs_code", ec0, 2'b11);
        chk("exs_addr", ea0, 8'hF3);
        chk("exs_data", ed0, 8'h55);
        chk("exs_exp", ex0, 8'h00);

        // 14-entry instance with wrapped values
        clear();
        for (int i = 0; i < 14; i++) wrt(8'(192 + i), fib1[i]);
        for (int k = 0; k < 13; k++) wrt(8'hB0, sums1[k]);
        chk("big_run", st1, 2'b01);
        chk("big_f_ok", f1_ok, 14'h3FFF);
        cyc();
        chk("big_pass", st1, 2'b10);
        chk("big_sum_ok", s1_ok, 13'h1FFF);
        chk("big_code", ec1, 2'b00);
        clear();
        for (int i = 0; i < 13; i++) wrt(8'(192 + i), fib1[i]);
        wrt(8'hCD, 8'h80);
        chk("wrap_state", st1, 2'b11);
        chk("wrap_code", ec1, 2'b01);
        chk("wrap_addr", ea1, 8'hCD);
        chk("wrap_exp", ex1, 8'h79);

        // Async reset between edges
        clear();
        wrt(8'hF8, 8'h01); wrt(8'hF9, 8'h01);
        chk("ar_pre", f0_ok, 7'h03);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_state", st0, 2'b00);
        chk("ar_f_ok", f0_ok, 7'h00);
        #1;
        rst_n = 1'b1;
        wrt(8'hF8, 8'h01);
        chk("ar_restart_f", f0_ok, 7'h01);
        chk("ar_restart_st", st0, 2'b01);

        // Randomized episodes against the model
        for (int ep = 0; ep < 30; ep++) begin
            clear();
            chk_model();
            for (int c = 0; c < 30; c++) begin
                r = $urandom_range(0, 99);
                wr = 1'b1; clr = 1'b0;
                data = 8'($urandom);
                if (r < 35) begin
                    addr = 8'(248 + (m_fi < 7 ? m_fi : 0));
                    if (m_fi < 7) data = fib[m_fi];
                end else if (r < 70) begin
                    addr = 8'hF3;
                    if (m_sk < 6) data = sums[m_sk];
                end else if (r < 78) begin
                    addr = 8'($urandom_range(248, 254));
                end else if (r < 84) begin
                    addr = 8'hF3;
                end else if (r < 92) begin
                    addr = 8'($urandom);
                end else if (r < 97) begin
                    wr = 1'b0;
                end else begin
                    clr = 1'b1;
                end
                cyc();
                chk_model();
            end
            wr = 1'b0; clr = 1'b0;
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
